// File: rtl/ahfp_sub_ci_ctrl_if.sv
// Custom-instruction bus between the CPU-side requester and the subtractor controller,
// including the operand/result taps to the attached free-running subtractor pipeline.
interface ahfp_sub_ci_ctrl_if;
  logic        clk_en;
  logic        start;
  logic        n;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] pipe_a;
  logic [31:0] pipe_b;
  logic [31:0] pipe_result;
  logic [31:0] result;
  logic        done;

  modport master (
    output clk_en, start, n, dataa, datab, pipe_result,
    input  pipe_a, pipe_b, result, done
  );

  modport slave (
    input  clk_en, start, n, dataa, datab, pipe_result,
    output pipe_a, pipe_b, result, done
  );
endinterface

// File: rtl/ahfp_sub_ci_ctrl.sv
// Multi-cycle custom-instruction controller for a fixed-latency FP subtractor.
// Optional AHFP_SUB_CI_ZERO_BYPASS_EN: subtrahend of +/-0 completes in one cycle.
module ahfp_sub_ci_ctrl #(
  parameter int LATENCY = 7
) (
  input  logic               clk,
  input  logic               reset,
  ahfp_sub_ci_ctrl_if.slave  ci
);
  localparam int CW = $clog2(LATENCY + 2);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   minu, subt;

  assign minu = ci.n ? ci.datab : ci.dataa;
  assign subt = ci.n ? ci.dataa : ci.datab;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ci.done   <= 1'b0;
      ci.result <= '0;
      ci.pipe_a <= '0;
      ci.pipe_b <= '0;
    end else if (ci.clk_en) begin
      case (state)
        IDLE: begin
          if (ci.start) begin
            // operands stay on the pipeline inputs until the next accepted start
            ci.pipe_a <= minu;
            ci.pipe_b <= subt;
`ifdef AHFP_SUB_CI_ZERO_BYPASS_EN
            if (subt[30:0] == 31'd0) begin
              state     <= DONE;
              ci.done   <= 1'b1;
              ci.result <= minu;
              cnt       <= '0;
            end else begin
`else
            begin
`endif
              state <= BUSY;
              cnt   <= CW'(LATENCY + 1);
            end
          end
        end
        BUSY: begin
          if (cnt == CW'(1)) begin
            ci.result <= ci.pipe_result;
            ci.done   <= 1'b1;
            state     <= DONE;
            cnt       <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          ci.done <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ahfp_sub_ci_ctrl.sv
// Directed bench for ahfp_sub_ci_ctrl with a behavioural 7-stage subtractor stand-in.
module tb_ahfp_sub_ci_ctrl;
  localparam int LAT = 7;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  ahfp_sub_ci_ctrl_if ci();

  ahfp_sub_ci_ctrl #(.LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .ci    (ci)
  );

  always #5 clk = ~clk;

  // Stand-in subtractor: 3.0-1.0 is exact, everything else is a recognisable xor tag.
  function automatic logic [31:0] sub_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4040_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
    return a ^ b;
  endfunction

  logic [31:0] stg [LAT];
  always @(posedge clk) begin
    stg[0] <= sub_fn(ci.pipe_a, ci.pipe_b);
    for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
  end
  assign ci.pipe_result = stg[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a start at the next negedge; returns #1 after the sampling edge E0.
  task automatic issue(input logic nn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ci.start = 1'b1; ci.n = nn; ci.dataa = a; ci.datab = b;
    @(posedge clk); #1;
    ci.start = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!ci.done && edges < 40);
  endtask

  int e, pulses, first;

  initial begin
    reset = 1'b1;
    ci.clk_en = 1'b1; ci.start = 1'b0; ci.n = 1'b0;
    ci.dataa = '0; ci.datab = '0;
    #3;
    chk("rst_done",   32'(ci.done), 32'd0);
    chk("rst_result", ci.result,    32'd0);
    chk("rst_pipe_a", ci.pipe_a,    32'd0);
    chk("rst_pipe_b", ci.pipe_b,    32'd0);
    @(negedge clk); reset = 1'b0;

    // basic n=0
    issue(1'b0, 32'h4040_0000, 32'h3F80_0000);
    chk("t1_pipe_a", ci.pipe_a, 32'h4040_0000);
    chk("t1_pipe_b", ci.pipe_b, 32'h3F80_0000);
    wait_done(e);
    chk("t1_latency", 32'(e), 32'd8);
    chk("t1_result", ci.result, 32'h4000_0000);
    @(posedge clk); #1;
    chk("t1_done_width", 32'(ci.done), 32'd0);

    // swapped operands, then done frozen by clk_en=0
    issue(1'b1, 32'h3F80_0000, 32'h4040_0000);
    chk("t2_pipe_a", ci.pipe_a, 32'h4040_0000);
    chk("t2_pipe_b", ci.pipe_b, 32'h3F80_0000);
    wait_done(e);
    chk("t2_latency", 32'(e), 32'd8);
    chk("t2_result", ci.result, 32'h4000_0000);
    ci.clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t2_done_frozen", 32'(ci.done), 32'd1);
    ci.clk_en = 1'b1;
    @(posedge clk); #1;
    chk("t2_done_clear", 32'(ci.done), 32'd0);

    // start held for 10 sampled edges with new operands after the first
    @(negedge clk);
    ci.start = 1'b1; ci.n = 1'b0; ci.dataa = 32'h4040_0000; ci.datab = 32'h3F80_0000;
    @(posedge clk); #1;
    ci.dataa = 32'h4120_0000; ci.datab = 32'h4000_0000;
    pulses = 0; first = 0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
      if (ci.done) begin
        pulses++;
        if (first == 0) first = i;
      end
      if (i == 9) ci.start = 1'b0;
    end
    chk("t3_pulses", 32'(pulses), 32'd1);
    chk("t3_first", 32'(first), 32'd8);
    chk("t3_result", ci.result, 32'h4000_0000);
    chk("t3_pipe_a", ci.pipe_a, 32'h4040_0000);

    // clk_en low for edges E3..E7
    issue(1'b0, 32'h4040_0000, 32'h3F80_0000);
    repeat (2) @(posedge clk);
    #1 ci.clk_en = 1'b0;
    repeat (5) @(posedge clk);
    #1 ci.clk_en = 1'b1;
    wait_done(e);
    chk("t4_latency", 32'(e + 7), 32'd13);
    chk("t4_result", ci.result, 32'h4000_0000);
    @(posedge clk); #1;
    chk("t4_done_width", 32'(ci.done), 32'd0);

    // reset mid-BUSY at E4
    issue(1'b0, 32'h4040_0000, 32'h3F80_0000);
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    #1;
    chk("t5_result", ci.result, 32'd0);
    chk("t5_pipe_a", ci.pipe_a, 32'd0);
    chk("t5_pipe_b", ci.pipe_b, 32'd0);
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ci.done) pulses++;
    end
    chk("t5_no_done", 32'(pulses), 32'd0);
    issue(1'b0, 32'h4040_0000, 32'h3F80_0000);
    wait_done(e);
    chk("t5_restart_lat", 32'(e), 32'd8);
    chk("t5_restart_res", ci.result, 32'h4000_0000);
    @(posedge clk); #1;

    // zero subtrahend (-0.0)
    issue(1'b0, 32'h4120_0000, 32'h8000_0000);
    chk("t6_pipe_b", ci.pipe_b, 32'h8000_0000);
`ifdef AHFP_SUB_CI_ZERO_BYPASS_EN
    chk("t6_bypass_done", 32'(ci.done), 32'd1);
    chk("t6_bypass_res", ci.result, 32'h4120_0000);
`else
    wait_done(e);
    chk("t6_latency", 32'(e), 32'd8);
    chk("t6_result", ci.result, 32'hC120_0000);
`endif
    @(posedge clk); #1;
    chk("t6_done_clear", 32'(ci.done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ahfp_sub_ci_ctrl.md
AHFP_SUB_CI_CTRL -- requirements
Module: ahfp_sub_ci_ctrl

Interface
REQ-001 Parameter: LATENCY, default 7, the fixed clk-to-result pipeline depth of the attached subtractor in clock edges.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 clk_en  input  1  custom-instruction clock enable; low freezes all controller state.
REQ-005 start  input  1  custom-instruction start strobe; sampled only when clk_en=1.
REQ-006 n  input  1  opcode bit: 0 = dataa-datab, 1 = datab-dataa (operand swap).
REQ-007 dataa  input  32  IEEE-754 single operand A.
REQ-008 datab  input  32  IEEE-754 single operand B.
REQ-009 pipe_a  output  32  minuend driven to subtractor pipeline.
REQ-010 pipe_b  output  32  subtrahend driven to subtractor pipeline.
REQ-011 pipe_result  input  32  result from subtractor pipeline.
REQ-012 result  output  32  captured instruction result.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY, DONE; all transitions require clk_en=1.
REQ-015 IDLE->BUSY on start=1: load pipe_a/pipe_b with {dataa,datab} (n=0) or {datab,dataa} (n=1); load a down-counter with LATENCY+1.
REQ-016 BUSY SHALL decrement the counter each enabled edge; on the edge where the counter is 1, capture pipe_result into result and go to DONE.
REQ-017 DONE SHALL assert done=1 for exactly one enabled cycle, then return to IDLE unconditionally.
REQ-018 done SHALL first be high in the cycle after enabled edge E0+LATENCY+1, where E0 is the edge sampling start (8 edges at default).
REQ-019 start while BUSY or DONE SHALL be ignored; no operand reload, no counter reload.
REQ-020 start in the same cycle DONE returns to IDLE SHALL be ignored; a new start is accepted only in IDLE.
REQ-021 pipe_a/pipe_b SHALL hold constant from load until the next accepted start, so clk_en stalls cannot corrupt the free-running pipeline.
REQ-022 clk_en=0 SHALL freeze state, counter, result and done (done remains at its current value).
REQ-023 result SHALL hold its last captured value until the next capture.
REQ-024 The counter SHALL be ceil(log2(LATENCY+2)) bits wide and never wrap below 0.

Reset
REQ-025 reset=1 SHALL immediately force state=IDLE, counter=0, done=0, result=0, pipe_a=0, pipe_b=0, independent of clk and clk_en.
REQ-026 reset asserted mid-BUSY SHALL abort the operation with no done pulse; first start after release behaves as from power-up.

Configuration
REQ-027 Macro AHFP_SUB_CI_ZERO_BYPASS_EN, when defined: an accepted start whose subtrahend after swap has bits[30:0]=0 SHALL go IDLE->DONE directly with result=minuend, done in the cycle after E0 (1-cycle latency), pipe_a/pipe_b still loaded.
REQ-028 Without AHFP_SUB_CI_ZERO_BYPASS_EN every operation SHALL take the full LATENCY+1 path of REQ-018.

Verification
REQ-029 Reset, then start, n=0, dataa=0x40400000, datab=0x3F800000 -> done one cycle, 8 edges after start edge, result=0x40000000.
REQ-030 n=1, dataa=0x3F800000, datab=0x40400000 -> pipe_a=0x40400000, pipe_b=0x3F800000, result=0x40000000 after 8 edges.
REQ-031 Start, then start held high for 10 cycles with new operands -> only one done pulse, result from first operands, pipe_a unchanged until next accepted start.
REQ-032 Start then clk_en=0 for 5 cycles at edge E0+3 -> done appears 13 edges after E0, result still correct, done width one enabled cycle.
REQ-033 Assert reset at edge E0+4 -> done never pulses, result=0, pipe_a/pipe_b=0; next start completes normally in 8 edges.
REQ-034 With AHFP_SUB_CI_ZERO_BYPASS_EN: dataa=0x41200000, datab=0x80000000 -> done 1 edge after start, result=0x41200000; without macro -> done after 8 edges.
